// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } fetch_state_e;

  // Encoding order is the redirect priority, so causes compare numerically.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    BRANCH = 2'd1,
    RET    = 2'd2,
    INTR   = 2'd3
  } redir_cause_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/if_stage.sv
// IF stage: owns the PC, arbitrates redirects and parks any that arrive while the pipe is stalled.
// im_addr/pc come straight from pc_q (zero latency); stalls hold pc_q and keep a pending redirect in tgt_q.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IFID_write,
  input  logic        im_stall,
  input  logic        dm_stall,
  input  logic        CSR_stall,
  input  logic        CSR_reset,
  input  logic        CSR_interrupt,
  input  logic        CSR_ret,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] im_rdata,
  output logic        im_req,
  output logic [31:0] im_addr,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        IFID_flush
);

  fetch_state_e state_q;
  redir_cause_e cause_q;
  logic [31:0]  pc_q;
  logic [31:0]  tgt_q;

  logic         adv;
  redir_cause_e new_cause;
  logic [31:0]  new_tgt;
  redir_cause_e win_cause;
  logic [31:0]  win_tgt;

  assign adv = IFID_write & ~im_stall & ~dm_stall & ~CSR_stall;

  always_comb begin
    new_cause = NONE;
    new_tgt   = 32'h0;
    if (CSR_interrupt) begin
      new_cause = INTR;
      new_tgt   = {csr_mtvec[31:2], 2'b00};
    end else if (CSR_ret) begin
      new_cause = RET;
      new_tgt   = {csr_mepc[31:2], 2'b00};
    end else if (branch_taken) begin
      new_cause = BRANCH;
      new_tgt   = {branch_target[31:2], 2'b00};
    end
  end

  // A fresh redirect displaces the parked one only at equal or higher priority.
  // With nothing parked cause_q is NONE, so any fresh redirect wins.
  always_comb begin
    win_cause = cause_q;
    win_tgt   = tgt_q;
    if ((new_cause != NONE) && (new_cause >= cause_q)) begin
      win_cause = new_cause;
      win_tgt   = new_tgt;
    end
  end

  always_comb begin
    IFID_flush = 1'b0;
    case (state_q)
      RUN:     IFID_flush = (new_cause != NONE);
      REDIR:   IFID_flush = adv;
      default: IFID_flush = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'h0;
      cause_q <= NONE;
    end else if (CSR_reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'h0;
      cause_q <= NONE;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN, REDIR: begin
          if (win_cause != NONE) begin
            if (adv) begin
              pc_q    <= win_tgt;
              cause_q <= NONE;
              state_q <= RUN;
            end else begin
              tgt_q   <= win_tgt;
              cause_q <= win_cause;
              state_q <= REDIR;
            end
          end else if (adv) begin
            pc_q <= pc_q + PC_STEP;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign im_req      = (state_q != BOOT);
  assign im_addr     = pc_q;
  assign pc          = pc_q;
  assign instruction = (state_q == BOOT) ? 32'h0 : im_rdata;

endmodule

// File: tb/tb_if_stage.sv
// Directed vector table, hand sequences for reset corners, then randomized run against a queue-free reference model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        IFID_write, im_stall, dm_stall, CSR_stall, CSR_reset;
  logic        CSR_interrupt, CSR_ret, branch_taken;
  logic [31:0] csr_mtvec, csr_mepc, branch_target, im_rdata;
  logic        im_req, IFID_flush;
  logic [31:0] im_addr, pc, instruction;

  int n_cmp = 0;
  int n_bad = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .IFID_write(IFID_write), .im_stall(im_stall),
    .dm_stall(dm_stall), .CSR_stall(CSR_stall), .CSR_reset(CSR_reset),
    .CSR_interrupt(CSR_interrupt), .CSR_ret(CSR_ret), .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc), .branch_taken(branch_taken), .branch_target(branch_target),
    .im_rdata(im_rdata), .im_req(im_req), .im_addr(im_addr), .pc(pc),
    .instruction(instruction), .IFID_flush(IFID_flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdf(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Instruction memory: returns a word derived from the address.
  assign im_rdata = rdf(im_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endtask

  task automatic drive(input logic [7:0] f, input logic [31:0] bt, input logic [31:0] mt,
                       input logic [31:0] me);
    {IFID_write, im_stall, dm_stall, CSR_stall, CSR_reset,
     CSR_interrupt, CSR_ret, branch_taken} = f;
    branch_target = bt;
    csr_mtvec     = mt;
    csr_mepc      = me;
  endtask

  typedef struct {
    logic [7:0]  flags;  // {IFID_write, im_stall, dm_stall, CSR_stall, CSR_reset, intr, ret, branch}
    logic [31:0] btgt, mtvec, mepc;
    logic        chkf, expf;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] f, input logic [31:0] bt, input logic [31:0] mt,
                     input logic [31:0] me, input logic cf, input logic ef, input logic [31:0] ea);
    vec_t v;
    v.flags = f; v.btgt = bt; v.mtvec = mt; v.mepc = me;
    v.chkf = cf; v.expf = ef; v.exp_addr = ea;
    tbl.push_back(v);
  endtask

  // Reference model state
  logic        m_boot, m_pend;
  logic [31:0] m_pc, m_ptgt;
  int          m_pprio;

  initial begin
    drive(8'b1000_0000, 0, 0, 0);
    reset = 1'b1;

    add(8'b1000_0001, 32'h20,        0,          0,          1, 1, 32'h20);
    add(8'b1000_0001, 32'h103,       0,          0,          1, 1, 32'h100);
    add(8'b1010_0001, 32'h200,       0,          0,          0, 0, 32'h100);
    add(8'b1010_0000, 0,             0,          0,          1, 0, 32'h100);
    add(8'b1010_0000, 0,             0,          0,          1, 0, 32'h100);
    add(8'b1000_0000, 0,             0,          0,          1, 1, 32'h200);
    add(8'b1000_0000, 0,             0,          0,          1, 0, 32'h204);
    add(8'b1001_0001, 32'h300,       0,          0,          0, 0, 32'h204);
    add(8'b1001_0100, 0,             32'h80,     0,          1, 0, 32'h204);
    add(8'b1000_0000, 0,             0,          0,          1, 1, 32'h80);
    add(8'b1100_0100, 0,             32'h90,     0,          0, 0, 32'h80);
    add(8'b1100_0001, 32'h400,       0,          0,          1, 0, 32'h80);
    add(8'b1000_0000, 0,             0,          0,          1, 1, 32'h90);
    add(8'b0000_0010, 0,             0,          32'h500,    0, 0, 32'h90);
    add(8'b1000_0001, 32'h600,       0,          0,          1, 1, 32'h500);
    add(8'b0000_0010, 0,             0,          32'h700,    0, 0, 32'h500);
    add(8'b1000_0010, 0,             0,          32'h706,    1, 1, 32'h704);
    add(8'b1000_0111, 32'h3000,      32'h1000,   32'h2000,   1, 1, 32'h1000);
    add(8'b1000_0001, 32'hFFFF_FFFC, 0,          0,          1, 1, 32'hFFFF_FFFC);
    add(8'b1000_0000, 0,             0,          0,          1, 0, 32'h0);
    add(8'b1000_0000, 0,             0,          0,          1, 0, 32'h4);
    add(8'b1010_0001, 32'h800,       0,          0,          0, 0, 32'h4);
    add(8'b1010_1000, 0,             0,          0,          1, 0, 32'h0);

    // Boot sequence
    @(posedge clk); #1;
    chk("rst_im_req", {31'b0, im_req}, 32'h0);
    chk("rst_im_addr", im_addr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_flush", {31'b0, IFID_flush}, 32'h0);
    reset = 1'b0;
    #1;
    chk("boot_im_req", {31'b0, im_req}, 32'h0);
    chk("boot_instr", instruction, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("seq_im_req", {31'b0, im_req}, 32'h1);
      chk("seq_im_addr", im_addr, 32'(i * 4));
      chk("seq_instr", instruction, rdf(32'(i * 4)));
    end

    // Directed table
    foreach (tbl[i]) begin
      drive(tbl[i].flags, tbl[i].btgt, tbl[i].mtvec, tbl[i].mepc);
      @(negedge clk);
      if (tbl[i].chkf) chk($sformatf("tbl%0d_flush", i), {31'b0, IFID_flush}, {31'b0, tbl[i].expf});
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_addr", i), im_addr, tbl[i].exp_addr);
    end

    // After CSR_reset in REDIR: back in BOOT, pending 0x800 must be gone
    chk("csrrst_im_req", {31'b0, im_req}, 32'h0);
    chk("csrrst_instr", instruction, 32'h0);
    drive(8'b1000_0000, 0, 0, 0);
    @(posedge clk); #1;
    chk("csrrst_run_addr", im_addr, 32'h0);
    chk("csrrst_run_req", {31'b0, im_req}, 32'h1);
    @(posedge clk); #1;
    chk("csrrst_seq_addr", im_addr, 32'h4);
    @(posedge clk); #1;
    chk("pre_arst_addr", im_addr, 32'h8);

    // Asynchronous reset while a branch is parked
    drive(8'b1010_0001, 32'h900, 0, 0);
    @(posedge clk); #1;
    drive(8'b1010_0000, 0, 0, 0);
    chk("arst_redir_hold", im_addr, 32'h8);
    #2 reset = 1'b1;
    #1;
    chk("arst_addr", im_addr, 32'h0);
    chk("arst_req", {31'b0, im_req}, 32'h0);
    chk("arst_instr", instruction, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(8'b1000_0000, 0, 0, 0);
    @(posedge clk); #1;
    chk("arst_run_addr", im_addr, 32'h0);
    @(posedge clk); #1;
    chk("arst_seq_addr", im_addr, 32'h4);

    // Randomized run against the reference model
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_boot = 1'b1; m_pend = 1'b0; m_pc = 32'h0; m_ptgt = 32'h0; m_pprio = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        adv;
      int          nprio;
      logic [31:0] ntgt;
      IFID_write    = ($urandom % 8) != 0;
      im_stall      = ($urandom % 6) == 0;
      dm_stall      = ($urandom % 8) == 0;
      CSR_stall     = ($urandom % 10) == 0;
      CSR_reset     = ($urandom % 150) == 0;
      CSR_interrupt = ($urandom % 20) == 0;
      CSR_ret       = ($urandom % 15) == 0;
      branch_taken  = ($urandom % 6) == 0;
      csr_mtvec     = $urandom;
      csr_mepc      = $urandom;
      branch_target = (($urandom % 4) == 0) ? 32'hFFFF_FFF0 | ($urandom % 16) : $urandom;
      adv = IFID_write && !im_stall && !dm_stall && !CSR_stall;
      if (CSR_interrupt)     begin nprio = 3; ntgt = csr_mtvec; end
      else if (CSR_ret)      begin nprio = 2; ntgt = csr_mepc; end
      else if (branch_taken) begin nprio = 1; ntgt = branch_target; end
      else                   begin nprio = 0; ntgt = 32'h0; end
      ntgt[1:0] = 2'b00;

      @(negedge clk);
      chk("rnd_im_req", {31'b0, im_req}, {31'b0, !m_boot});
      chk("rnd_im_addr", im_addr, m_pc);
      chk("rnd_pc", pc, m_pc);
      chk("rnd_instr", instruction, m_boot ? 32'h0 : rdf(m_pc));
      if (adv) chk("rnd_flush", {31'b0, IFID_flush},
                   {31'b0, !m_boot && (m_pend || nprio != 0)});

      @(posedge clk);
      if (CSR_reset) begin
        m_boot = 1'b1; m_pc = 32'h0; m_pend = 1'b0; m_pprio = 0;
      end else if (m_boot) begin
        m_boot = 1'b0;
      end else begin
        if (nprio != 0 && (!m_pend || nprio >= m_pprio)) begin
          m_pend = 1'b1; m_ptgt = ntgt; m_pprio = nprio;
        end
        if (adv) begin
          if (m_pend) begin
            m_pc = m_ptgt; m_pend = 1'b0; m_pprio = 0;
          end else begin
            m_pc = m_pc + 32'd4;
          end
        end
      end
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
